// File: rtl/exe_stage_if.sv
// ID-to-EXE handshake and decode bundle for the execute stage.
// ID drives the instruction fields; EXE answers with allow-in.
interface exe_stage_if;
    logic        ds_to_es_valid;
    logic        es_allow_in;
    logic [31:0] in_pc;
    logic [32:0] in_alu_src1;
    logic [32:0] in_alu_src2;
    logic [17:0] in_alu_op;
    logic        in_sram_en;
    logic [31:0] in_sram_addr;
    logic [31:0] in_sram_wdata;
    logic [3:0]  in_rf_we;
    logic [4:0]  in_rf_waddr;
    logic [3:0]  in_mem_op;

    modport master (
        output ds_to_es_valid, in_pc, in_alu_src1, in_alu_src2, in_alu_op,
               in_sram_en, in_sram_addr, in_sram_wdata, in_rf_we, in_rf_waddr,
               in_mem_op,
        input  es_allow_in
    );

    modport slave (
        input  ds_to_es_valid, in_pc, in_alu_src1, in_alu_src2, in_alu_op,
               in_sram_en, in_sram_addr, in_sram_wdata, in_rf_we, in_rf_waddr,
               in_mem_op,
        output es_allow_in
    );
endinterface

// File: rtl/exe_stage.sv
// LoongArch execute stage: ALU, 33x33 multiplier and iterative radix-2 divider,
// with valid/allow-in handshake toward MEM and forwarding info toward ID.
module exe_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int unsigned DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    exe_stage_if.slave  ds_if,
    input  logic        ms_allow_in,
    output logic        es_to_ms_valid,
    output logic        es_valid,
    output logic [31:0] es_pc,
    output logic [31:0] es_result,
    output logic        es_sram_en,
    output logic [31:0] es_sram_addr,
    output logic [31:0] es_sram_wdata,
    output logic [3:0]  es_mem_op,
    output logic [3:0]  es_rf_we,
    output logic [4:0]  es_rf_waddr,
    output logic        es_fwd_ok,
    output logic        es_div_busy
);

    localparam int unsigned CNT_W     = 5;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITER - 1);

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    logic        es_valid_q, es_valid_d;
    logic [31:0] pc_q, pc_d;
    logic [32:0] src1_q, src1_d;
    logic [32:0] src2_q, src2_d;
    logic [17:0] alu_op_q, alu_op_d;
    logic        sram_en_q, sram_en_d;
    logic [31:0] sram_addr_q, sram_addr_d;
    logic [31:0] sram_wdata_q, sram_wdata_d;
    logic [3:0]  rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [3:0]  mem_op_q, mem_op_d;

    logic [1:0]       div_state_q, div_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      rem_q, rem_d;
    logic [31:0]      dvsr_q, dvsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;

    logic        is_div_c;
    logic        ready_go_c;
    logic        allow_in_c;
    logic        capture_c;

    assign is_div_c   = |alu_op_q[17:14];
    assign ready_go_c = !is_div_c || (div_state_q == DIV_DONE);
    assign allow_in_c = !es_valid_q || (ready_go_c && ms_allow_in);
    assign capture_c  = ds_if.ds_to_es_valid && allow_in_c;

    assign ds_if.es_allow_in = allow_in_c;
    assign es_to_ms_valid    = es_valid_q && ready_go_c;
    assign es_fwd_ok         = es_valid_q && ready_go_c && !mem_op_q[3];
    assign es_div_busy       = (div_state_q == DIV_BUSY);

    assign es_valid      = es_valid_q;
    assign es_pc         = pc_q;
    assign es_sram_en    = sram_en_q;
    assign es_sram_addr  = sram_addr_q;
    assign es_sram_wdata = sram_wdata_q;
    assign es_mem_op     = mem_op_q;
    assign es_rf_we      = rf_we_q;
    assign es_rf_waddr   = rf_waddr_q;

    // Pipeline register: load the decode bundle whenever ID hands one over.
    always_comb begin
        es_valid_d   = es_valid_q;
        pc_d         = pc_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        alu_op_d     = alu_op_q;
        sram_en_d    = sram_en_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        rf_we_d      = rf_we_q;
        rf_waddr_d   = rf_waddr_q;
        mem_op_d     = mem_op_q;
        if (allow_in_c) begin
            es_valid_d = ds_if.ds_to_es_valid;
        end
        if (capture_c) begin
            pc_d         = ds_if.in_pc;
            src1_d       = ds_if.in_alu_src1;
            src2_d       = ds_if.in_alu_src2;
            alu_op_d     = ds_if.in_alu_op;
            sram_en_d    = ds_if.in_sram_en;
            sram_addr_d  = ds_if.in_sram_addr;
            sram_wdata_d = ds_if.in_sram_wdata;
            rf_we_d      = ds_if.in_rf_we;
            rf_waddr_d   = ds_if.in_rf_waddr;
            mem_op_d     = ds_if.in_mem_op;
        end
    end

    // Divider operand preparation and one restoring iteration.
    logic        div_signed_c;
    logic        a_neg_c, b_neg_c;
    logic [31:0] a_mag_c, b_mag_c;
    logic        ge_c;
    logic [31:0] diff_c;
    logic [63:0] step_c;
    logic [31:0] q_fix_c, r_fix_c;

    assign div_signed_c = alu_op_q[14] || alu_op_q[15];
    assign a_neg_c      = div_signed_c && src1_q[31];
    assign b_neg_c      = div_signed_c && src2_q[31];
    assign a_mag_c      = a_neg_c ? (~src1_q[31:0] + 32'd1) : src1_q[31:0];
    assign b_mag_c      = b_neg_c ? (~src2_q[31:0] + 32'd1) : src2_q[31:0];

    assign ge_c   = rem_q[63:31] >= {1'b0, dvsr_q};
    assign diff_c = rem_q[62:31] - dvsr_q;
    assign step_c = ge_c ? {diff_c, rem_q[30:0], 1'b1} : {rem_q[62:0], 1'b0};

    // Zero divisor forces an all-ones quotient regardless of operand signs.
    assign q_fix_c = dz_q    ? 32'hFFFF_FFFF
                   : q_neg_q ? (~step_c[31:0] + 32'd1) : step_c[31:0];
    assign r_fix_c = r_neg_q ? (~step_c[63:32] + 32'd1) : step_c[63:32];

    // Divider FSM next state; rem holds {remainder, quotient} once DONE.
    always_comb begin
        div_state_d = div_state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvsr_d      = dvsr_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_d        = dz_q;
        case (div_state_q)
            DIV_IDLE: begin
                if (es_valid_q && is_div_c) begin
                    div_state_d = DIV_BUSY;
                    cnt_d       = '0;
                    rem_d       = {32'd0, a_mag_c};
                    dvsr_d      = b_mag_c;
                    q_neg_d     = a_neg_c ^ b_neg_c;
                    r_neg_d     = a_neg_c;
                    dz_d        = (src2_q[31:0] == 32'd0);
                end
            end
            DIV_BUSY: begin
                rem_d = step_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    div_state_d = DIV_DONE;
                    rem_d       = {r_fix_c, q_fix_c};
                end
            end
            DIV_DONE: begin
                if (ms_allow_in) begin
                    div_state_d = DIV_IDLE;
                end
            end
            default: div_state_d = DIV_IDLE;
        endcase
    end

    // Result mux over the one-hot operation select.
    logic signed [32:0] m1_c, m2_c;
    logic signed [63:0] prod_c;
    logic [31:0]        a_c, b_c, add_c;
    logic [31:0]        alu_res_c;

    assign m1_c   = src1_q;
    assign m2_c   = src2_q;
    assign prod_c = 64'(m1_c) * 64'(m2_c);
    assign a_c    = src1_q[31:0];
    assign b_c    = src2_q[31:0];
    assign add_c  = a_c + b_c;

    always_comb begin
        alu_res_c = 32'd0;
        if (alu_op_q[0])  alu_res_c = alu_res_c | add_c;
        if (alu_op_q[1])  alu_res_c = alu_res_c | (a_c - b_c);
        if (alu_op_q[2])  alu_res_c = alu_res_c | {31'd0, $signed(a_c) < $signed(b_c)};
        if (alu_op_q[3])  alu_res_c = alu_res_c | {31'd0, a_c < b_c};
        if (alu_op_q[4])  alu_res_c = alu_res_c | (a_c & b_c);
        if (alu_op_q[5])  alu_res_c = alu_res_c | ~(a_c | b_c);
        if (alu_op_q[6])  alu_res_c = alu_res_c | (a_c | b_c);
        if (alu_op_q[7])  alu_res_c = alu_res_c | (a_c ^ b_c);
        if (alu_op_q[8])  alu_res_c = alu_res_c | (a_c << b_c[4:0]);
        if (alu_op_q[9])  alu_res_c = alu_res_c | (a_c >> b_c[4:0]);
        if (alu_op_q[10]) alu_res_c = alu_res_c | 32'($signed(a_c) >>> b_c[4:0]);
        if (alu_op_q[11]) alu_res_c = alu_res_c | b_c;
        if (alu_op_q[12]) alu_res_c = alu_res_c | prod_c[63:32];
        if (alu_op_q[13]) alu_res_c = alu_res_c | prod_c[31:0];
        if (alu_op_q[14] || alu_op_q[16]) alu_res_c = alu_res_c | rem_q[31:0];
        if (alu_op_q[15] || alu_op_q[17]) alu_res_c = alu_res_c | rem_q[63:32];
        // Memory ops always present the effective address computed by the adder.
        if (sram_en_q) alu_res_c = add_c;
    end

    assign es_result = alu_res_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            es_valid_q   <= 1'b0;
            pc_q         <= RESET_PC;
            src1_q       <= '0;
            src2_q       <= '0;
            alu_op_q     <= '0;
            sram_en_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            rf_we_q      <= '0;
            rf_waddr_q   <= '0;
            mem_op_q     <= '0;
        end else begin
            es_valid_q   <= es_valid_d;
            pc_q         <= pc_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            alu_op_q     <= alu_op_d;
            sram_en_q    <= sram_en_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            mem_op_q     <= mem_op_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_state_q <= DIV_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            div_state_q <= div_state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvsr_q      <= dvsr_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dz_q        <= dz_d;
        end
    end

endmodule
